apu_resp_checker: RTL

APU_RESP_CHECKER -- requirements
Module: apu_resp_checker

---
 rtl/apu_resp_checker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apu_resp_checker.sv
// rtl/apu_resp_checker.sv - scoreboard comparing tagged APU results against expected entries
module apu_resp_checker #(
    parameter int TAG_WIDTH = 4,
    parameter int TOL_ULP   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 exp_valid_i,
    output logic                 exp_ready_o,
    input  logic [TAG_WIDTH-1:0] exp_tag_i,
    input  logic [31:0]          exp_result_i,
    input  logic                 exp_is_int_i,
    input  logic                 resp_valid_i,
    input  logic [TAG_WIDTH-1:0] resp_tag_i,
    input  logic [31:0]          resp_result_i,
    output logic                 mismatch_o,
    output logic [TAG_WIDTH-1:0] mismatch_tag_o,
    output logic [31:0]          mismatch_exp_o,
    output logic [31:0]          mismatch_got_o,
    output logic [15:0]          pass_cnt_o,
    output logic [15:0]          fail_cnt_o,
    output logic [15:0]          unexp_cnt_o,
    output logic [TAG_WIDTH:0]   outstanding_o,
    output logic                 idle_o
);

    localparam int          N   = 2 ** TAG_WIDTH;
    localparam logic [31:0] TOL = 32'(TOL_ULP);

    logic [N-1:0]         valid_q;
    logic [31:0]          exp_mem [N];
    logic                 int_mem [N];
    logic [TAG_WIDTH:0]   out_q;

    logic                 push;
    logic                 hit;
    logic                 unexp;
    logic                 cmp_pass;
    logic [N-1:0]         set_mask;
    logic [N-1:0]         clr_mask;

    logic [31:0]          cmp_exp;
    logic [31:0]          cmp_got;
    logic [31:0]          ulp_diff;
    logic                 exp_nan;
    logic                 got_nan;

    // Readiness depends only on the current table, so a same-cycle retire of
    // the same tag cannot open the slot early.
    assign exp_ready_o = !valid_q[exp_tag_i] && !clear_i;
    assign push        = exp_valid_i && exp_ready_o;
    assign hit         = resp_valid_i && valid_q[resp_tag_i];
    assign unexp       = resp_valid_i && !valid_q[resp_tag_i];

    assign outstanding_o = out_q;
    assign idle_o        = (out_q == '0);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        cmp_exp  = exp_mem[resp_tag_i];
        cmp_got  = resp_result_i;
        // Magnitude distance over the 31 non-sign bits; ordering first so the
        // subtraction never wraps.
        ulp_diff = (cmp_exp[30:0] >= cmp_got[30:0])
                 ? {1'b0, cmp_exp[30:0]} - {1'b0, cmp_got[30:0]}
                 : {1'b0, cmp_got[30:0]} - {1'b0, cmp_exp[30:0]};
        exp_nan  = (cmp_exp[30:23] == 8'hFF) && (cmp_exp[22:0] != '0);
        got_nan  = (cmp_got[30:23] == 8'hFF) && (cmp_got[22:0] != '0);
        if (int_mem[resp_tag_i]) begin
            cmp_pass = (cmp_exp == cmp_got);
        end else begin
            cmp_pass = (exp_nan && got_nan)
                    || (cmp_exp == cmp_got)
                    || ((cmp_exp[30:0] == '0) && (cmp_got[30:0] == '0))
                    || ((cmp_exp[31] == cmp_got[31]) && (ulp_diff <= TOL));
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (push) set_mask[exp_tag_i]  = 1'b1;
        if (hit)  clr_mask[resp_tag_i] = 1'b1;
    end

    // Expected payloads are only read behind a valid bit, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            exp_mem[exp_tag_i] <= exp_result_i;
            int_mem[exp_tag_i] <= exp_is_int_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q        <= '0;
            out_q          <= '0;
            pass_cnt_o     <= '0;
            fail_cnt_o     <= '0;
            unexp_cnt_o    <= '0;
            mismatch_o     <= 1'b0;
            mismatch_tag_o <= '0;
            mismatch_exp_o <= '0;
            mismatch_got_o <= '0;
        end else if (clear_i) begin
            valid_q     <= '0;
            out_q       <= '0;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            unexp_cnt_o <= '0;
            mismatch_o  <= 1'b0;
        end else begin
            // Push and retire never target the same tag: push needs the
            // slot empty, retire needs it full.
            valid_q <= (valid_q & ~clr_mask) | set_mask;

            case ({push, hit})
                2'b10:   out_q <= out_q + 1'b1;
                2'b01:   out_q <= out_q - 1'b1;
                default: out_q <= out_q;
            endcase

            mismatch_o <= 1'b0;
            if (hit) begin
                if (cmp_pass) begin
                    pass_cnt_o <= sat_inc(pass_cnt_o);
                end else begin
                    fail_cnt_o     <= sat_inc(fail_cnt_o);
                    mismatch_o     <= 1'b1;
                    mismatch_tag_o <= resp_tag_i;
                    mismatch_exp_o <= cmp_exp;
                    mismatch_got_o <= resp_result_i;
                end
            end else if (unexp) begin
                unexp_cnt_o    <= sat_inc(unexp_cnt_o);
                mismatch_o     <= 1'b1;
                mismatch_tag_o <= resp_tag_i;
                mismatch_exp_o <= '0;
                mismatch_got_o <= resp_result_i;
            end
        end
    end

endmodule
